// File: rtl/event_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : event_uart_reporter
//  Description : Timestamps spike/class events, queues them in a record FIFO
//                and ships each record as a 3-byte 8N1 UART frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module event_uart_reporter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spike_in,
    input  logic [1:0] event_in,
    input  logic       report_spikes,
    input  logic       ts_clear,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   c_DEPTH    = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [15:0]   r_ts;
    logic [17:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_busy;
    logic [7:0]    r_drop;

    logic [1:0]    r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [1:0]    r_byte_idx;
    logic [17:0]   r_frame;
    logic          r_tx;

    logic          w_push;
    logic          w_wr_en;
    logic          w_drop;
    logic          w_empty;
    logic [17:0]   w_rec;
    logic [17:0]   w_head;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_cur_byte;
    logic [2:0]    w_bit_inc;
    logic          w_bit_end;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_bit_nxt;
    logic [1:0]    w_byte_nxt;
    logic [17:0]   w_frame_nxt;
    logic          w_tx_nxt;
    logic          w_pop;

    // A class code always wins over a coincident spike, so one record per edge.
    assign w_push  = (event_in != 2'b00) | (spike_in & report_spikes);
    assign w_rec   = {event_in, r_ts};
    assign w_wr_en = w_push & ~r_full;
    assign w_drop  = w_push & r_full;
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    assign w_cur_byte = (r_byte_idx == 2'd0) ? {4'hA, 2'b00, r_frame[17:16]} :
                        (r_byte_idx == 2'd1) ? r_frame[15:8] : r_frame[7:0];
    assign w_bit_inc  = r_bit_idx + 3'd1;
    assign w_bit_end  = (r_clk_cnt == c_BIT_LAST);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
            2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_clk_cnt + CW'(1);
        w_bit_nxt   = r_bit_idx;
        w_byte_nxt  = r_byte_idx;
        w_frame_nxt = r_frame;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_frame_nxt = w_head;
                    w_byte_nxt  = 2'd0;
                    w_state_nxt = c_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = c_DATA;
                    w_tx_nxt    = w_cur_byte[0];
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = c_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = w_cur_byte[w_bit_inc];
                    end
                end
            end
            c_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_byte_idx != 2'd2) begin
                        w_byte_nxt  = r_byte_idx + 2'd1;
                        w_state_nxt = c_START;
                        w_tx_nxt    = 1'b0;
                    end else if (!w_empty) begin
                        // Chain straight into the next frame without an idle bit.
                        w_pop       = 1'b1;
                        w_frame_nxt = w_head;
                        w_byte_nxt  = 2'd0;
                        w_state_nxt = c_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_frame    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_byte_idx <= w_byte_nxt;
            r_frame    <= w_frame_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // The record captured on a clearing edge still carries the old count.
    always_ff @(posedge clk) begin
        if (!rst || ts_clear) begin
            r_ts <= 16'h0000;
        end else begin
            r_ts <= r_ts + 16'h0001;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_busy   <= 1'b0;
            r_drop   <= 8'h00;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_busy  <= (w_state_nxt != c_IDLE) | (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = r_full;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_event_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_uart_reporter
//  Description : Directed self-checking bench for event_uart_reporter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_uart_reporter;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       clk           = 1'b0;
    logic       rst           = 1'b0;
    logic       spike_in      = 1'b0;
    logic [1:0] event_in      = 2'b00;
    logic       report_spikes = 1'b0;
    logic       ts_clear      = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    event_uart_reporter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spike_in      (spike_in),
        .event_in      (event_in),
        .report_spikes (report_spikes),
        .ts_clear      (ts_clear),
        .tx            (tx),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] cls(input int i);
        return 2'((i % 3) + 1);
    endfunction

    // Waits (bounded) for a start bit, then samples each bit at its centre.
    task automatic rx_byte(input int timeout, output logic [7:0] data,
                           output logic ok, output int fall_cyc);
        int   n;
        logic found;
        logic s_start;
        logic s_stop;
        n = 0; found = 1'b0; ok = 1'b0; data = 8'h00; fall_cyc = -1;
        while (!found && n < timeout) begin
            @(posedge clk); #1;
            if (tx === 1'b0) found = 1'b1;
            n++;
        end
        if (found) begin
            fall_cyc = cyc;
            repeat (CPB / 2) @(posedge clk);
            #1 s_start = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 data[i] = tx;
            end
            repeat (CPB) @(posedge clk);
            #1 s_stop = tx;
            ok = (s_start === 1'b0) && (s_stop === 1'b1);
        end
    endtask

    task automatic rx_frame(input int timeout, output logic [23:0] f,
                            output logic ok, output int fall0);
        logic [7:0] b;
        logic       k;
        int         fc;
        rx_byte(timeout, b, k, fall0);
        f[23:16] = b; ok = k;
        rx_byte(CPB, b, k, fc);
        f[15:8] = b; ok = ok & k;
        rx_byte(CPB, b, k, fc);
        f[7:0] = b; ok = ok & k;
    endtask

    task automatic clear_ts();
        @(negedge clk); ts_clear = 1'b1;
        @(negedge clk); ts_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        rst = 1'b1;
    endtask

    task automatic test_single_event();
        logic [23:0] f;
        logic        ok;
        int          f0;
        int          c_push;
        clear_ts();
        repeat (5) @(negedge clk);
        event_in = 2'b10;
        @(negedge clk); event_in = 2'b00;
        c_push = cyc;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_pre: got %b expected 1", tx); end
        rx_frame(4, f, ok, f0);
        checks++; if (f0 != c_push + 1) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", f0, c_push + 1); end
        checks++; if (!ok || f !== 24'hA20005) begin errors++; $display("FAIL single_frame: got %h ok=%b expected a20005", f, ok); end
        repeat (7) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL single_stop_hold: got busy=%b tx=%b expected busy=1 tx=1", busy, tx); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0 at 480 cycles", busy); end
    endtask

    task automatic test_overflow();
        logic [23:0] got [9];
        logic        gok [9];
        int          fc;
        logic [23:0] exp;
        clear_ts();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    event_in = cls(i);
                    @(negedge clk);
                    if (i == 7) begin
                        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full7: got %b expected 0", fifo_full); end
                    end
                    if (i == 8) begin
                        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full8: got %b expected 1", fifo_full); end
                    end
                end
                event_in = 2'b00;
                checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", drop_count); end
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_frame((i == 0) ? 40 : CPB, got[i], gok[i], fc);
                end
            end
        join
        for (int i = 0; i < 9; i++) begin
            exp = {4'hA, 2'b00, cls(i), 8'h00, 8'(i)};
            checks++; if (!gok[i] || got[i] !== exp) begin errors++; $display("FAIL ovf_frame%0d: got %h ok=%b expected %h", i, got[i], gok[i], exp); end
        end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL ovf_no_tenth: got busy=%b tx=%b expected 0/1", busy, tx); end
    endtask

    task automatic test_priority();
        logic [23:0] f;
        logic        ok;
        int          f0;
        clear_ts();
        report_spikes = 1'b1; spike_in = 1'b1; event_in = 2'b01;
        @(negedge clk); spike_in = 1'b0; event_in = 2'b00;
        rx_frame(4, f, ok, f0);
        checks++; if (!ok || f !== 24'hA10000) begin errors++; $display("FAIL prio_frame: got %h ok=%b expected a10000", f, ok); end
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_single: got busy=%b expected 0", busy); end
        @(negedge clk); report_spikes = 1'b0; spike_in = 1'b1;
        @(negedge clk); spike_in = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL filter_off: got busy=%b tx=%b expected 0/1", busy, tx); end
        report_spikes = 1'b1;
        clear_ts();
        repeat (3) @(negedge clk);
        spike_in = 1'b1;
        @(negedge clk); spike_in = 1'b0;
        rx_frame(4, f, ok, f0);
        checks++; if (!ok || f !== 24'hA00003) begin errors++; $display("FAIL filter_on: got %h ok=%b expected a00003", f, ok); end
        repeat (20) @(posedge clk);
        report_spikes = 1'b0;
    endtask

    task automatic test_timestamp();
        logic [23:0] got [4];
        logic        gok [4];
        logic [23:0] exp [4];
        int          fc;
        exp[0] = 24'hA3FFFF; exp[1] = 24'hA10000; exp[2] = 24'hA20001; exp[3] = 24'hA30000;
        clear_ts();
        repeat (65535) @(negedge clk);
        event_in = 2'b11;
        @(negedge clk);
        fork
            begin
                event_in = 2'b01;
                @(negedge clk); ts_clear = 1'b1; event_in = 2'b10;
                @(negedge clk); ts_clear = 1'b0; event_in = 2'b11;
                @(negedge clk); event_in = 2'b00;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    rx_frame((i == 0) ? 4 : CPB, got[i], gok[i], fc);
                end
            end
        join
        for (int i = 0; i < 4; i++) begin
            checks++; if (!gok[i] || got[i] !== exp[i]) begin errors++; $display("FAIL ts_frame%0d: got %h ok=%b expected %h", i, got[i], gok[i], exp[i]); end
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int saw_low;
        clear_ts();
        event_in = 2'b01;
        @(negedge clk); event_in = 2'b10;
        @(negedge clk); event_in = 2'b11;
        @(negedge clk); event_in = 2'b00;
        repeat (198) @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL rstmid_pre: got tx=%b busy=%b drop=%0d expected 0/1/1", tx, busy, drop_count); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0 || fifo_full !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got busy=%b full=%b expected 0/0", busy, fifo_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rstmid_drop: got %0d expected 0", drop_count); end
        @(negedge clk); rst = 1'b1;
        saw_low = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) saw_low++;
        end
        checks++; if (saw_low != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", saw_low); end
    endtask

    task automatic test_saturation();
        @(negedge clk); event_in = 2'b01;
        repeat (263) @(negedge clk);
        checks++; if (drop_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", drop_count); end
        repeat (46) @(negedge clk);
        event_in = 2'b00;
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", drop_count); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL sat_full: got %b expected 1", fifo_full); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_overflow();
        test_priority();
        test_timestamp();
        test_reset_mid_frame();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
